// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: data-memory wait freeze with timeout error, taken-branch flush
// and load-use stall. Define STALL_CNT_EN to build the saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IDEXMemRead_in,
  input  logic [4:0]  IDEXRd_in,
  input  logic [4:0]  IFIDRs1_in,
  input  logic [4:0]  IFIDRs2_in,
  input  logic        BranchTaken_in,
  input  logic        MEMReq_in,
  input  logic        DmemReady_in,
  output logic        PCWrite_out,
  output logic        IFIDWrite_out,
  output logic        IDEXWrite_out,
  output logic        EXMEMWrite_out,
  output logic        IFIDFlush_out,
  output logic        IDEXFlush_out,
  output logic        MEMWBBubble_out,
  output logic        MemErr_out,
  output logic [31:0] StallCnt_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  state_t     state, state_next;
  logic [3:0] wait_cnt, wait_cnt_next;
  logic       freeze;
  logic       load_use;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    freeze        = 1'b0;
    case (state)
      IDLE: begin
        if (MEMReq_in && !DmemReady_in) begin
          freeze        = 1'b1;
          state_next    = WAIT;
          wait_cnt_next = 4'd1;
        end
      end
      WAIT: begin
        if (DmemReady_in) begin
          state_next    = IDLE;
          wait_cnt_next = 4'd0;
        end else begin
          freeze = 1'b1;
          if (wait_cnt == TIMEOUT_CNT) begin
            state_next = ERR;
          end else begin
            wait_cnt_next = wait_cnt + 4'd1;
          end
        end
      end
      ERR: begin
        freeze = 1'b1;
      end
      default: begin
        state_next    = IDLE;
        wait_cnt_next = 4'd0;
      end
    endcase
  end

  // A load into x0 never produces a value worth waiting for.
  assign load_use = IDEXMemRead_in && (IDEXRd_in != 5'd0) &&
                    ((IDEXRd_in == IFIDRs1_in) || (IDEXRd_in == IFIDRs2_in));

  always_comb begin
    PCWrite_out     = 1'b0;
    IFIDWrite_out   = 1'b0;
    IDEXWrite_out   = 1'b0;
    EXMEMWrite_out  = 1'b0;
    IFIDFlush_out   = 1'b0;
    IDEXFlush_out   = 1'b0;
    MEMWBBubble_out = 1'b0;
    MemErr_out      = 1'b0;
    if (!rst) begin
      MemErr_out = (state == ERR);
      if (freeze) begin
        MEMWBBubble_out = 1'b1;
      end else if (BranchTaken_in) begin
        PCWrite_out    = 1'b1;
        IFIDWrite_out  = 1'b1;
        IDEXWrite_out  = 1'b1;
        EXMEMWrite_out = 1'b1;
        IFIDFlush_out  = 1'b1;
        IDEXFlush_out  = 1'b1;
      end else if (load_use) begin
        IDEXWrite_out  = 1'b1;
        EXMEMWrite_out = 1'b1;
        IDEXFlush_out  = 1'b1;
      end else begin
        PCWrite_out    = 1'b1;
        IFIDWrite_out  = 1'b1;
        IDEXWrite_out  = 1'b1;
        EXMEMWrite_out = 1'b1;
      end
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 32'd0;
    end else if (!PCWrite_out && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign StallCnt_out = stall_cnt;
`else
  assign StallCnt_out = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (TIMEOUT=4); expectations are hand-computed constants.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic [4:0]  rd, rs1, rs2;
  logic        branch;
  logic        mem_req;
  logic        ready;
  logic        pc_write, ifid_write, idex_write, exmem_write;
  logic        ifid_flush, idex_flush, bubble, mem_err;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  // Packed view: {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush, Bubble, MemErr}
  wire [7:0] outs = {pc_write, ifid_write, idex_write, exmem_write,
                     ifid_flush, idex_flush, bubble, mem_err};

  localparam logic [7:0] O_RESET  = 8'b0000_0000;
  localparam logic [7:0] O_NORMAL = 8'b1111_0000;
  localparam logic [7:0] O_LDUSE  = 8'b0011_0100;
  localparam logic [7:0] O_BRANCH = 8'b1111_1100;
  localparam logic [7:0] O_FREEZE = 8'b0000_0010;
  localparam logic [7:0] O_ERR    = 8'b0000_0011;

  pipeline_hazard_ctrl #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .IDEXMemRead_in (mem_read),
    .IDEXRd_in      (rd),
    .IFIDRs1_in     (rs1),
    .IFIDRs2_in     (rs2),
    .BranchTaken_in (branch),
    .MEMReq_in      (mem_req),
    .DmemReady_in   (ready),
    .PCWrite_out    (pc_write),
    .IFIDWrite_out  (ifid_write),
    .IDEXWrite_out  (idex_write),
    .EXMEMWrite_out (exmem_write),
    .IFIDFlush_out  (ifid_flush),
    .IDEXFlush_out  (idex_flush),
    .MEMWBBubble_out(bubble),
    .MemErr_out     (mem_err),
    .StallCnt_out   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read = 1'b0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    branch = 1'b0; mem_req = 1'b0; ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_read = 1'b1; rd = 5'd5; rs1 = 5'd5; rs2 = 5'd0;
    branch = 1'b0; mem_req = 1'b1; ready = 1'b0;
    #2;
    total++;
    if (outs !== O_RESET) begin
      bad++; $display("FAIL reset_outs: got %b want %b", outs, O_RESET);
    end
    tick();
    total++;
    if (outs !== O_RESET) begin
      bad++; $display("FAIL reset_outs_after_edge: got %b want %b", outs, O_RESET);
    end
    total++;
    if (stall_cnt !== 32'd0) begin
      bad++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
    end
    idle_inputs();
    rst = 1'b0;
    #1;
    total++;
    if (outs !== O_NORMAL) begin
      bad++; $display("FAIL post_reset_normal: got %b want %b", outs, O_NORMAL);
    end
    tick();
  endtask

  task automatic test_load_use();
    mem_read = 1'b1; rd = 5'd5; rs1 = 5'd3; rs2 = 5'd5;
    #1;
    total++;
    if (outs !== O_LDUSE) begin
      bad++; $display("FAIL load_use_rs2: got %b want %b", outs, O_LDUSE);
    end
    tick();
    mem_read = 1'b0;
    #1;
    total++;
    if (outs !== O_NORMAL) begin
      bad++; $display("FAIL load_use_one_cycle: got %b want %b", outs, O_NORMAL);
    end
    mem_read = 1'b1; rd = 5'd7; rs1 = 5'd7; rs2 = 5'd1;
    #1;
    total++;
    if (outs !== O_LDUSE) begin
      bad++; $display("FAIL load_use_rs1: got %b want %b", outs, O_LDUSE);
    end
    rs1 = 5'd6;
    #1;
    total++;
    if (outs !== O_NORMAL) begin
      bad++; $display("FAIL load_no_match: got %b want %b", outs, O_NORMAL);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_rd_zero();
    mem_read = 1'b1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    #1;
    total++;
    if (outs !== O_NORMAL) begin
      bad++; $display("FAIL rd_zero_no_stall: got %b want %b", outs, O_NORMAL);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_branch_priority();
    mem_read = 1'b1; rd = 5'd9; rs1 = 5'd9; rs2 = 5'd2; branch = 1'b1;
    #1;
    total++;
    if (outs !== O_BRANCH) begin
      bad++; $display("FAIL branch_over_load_use: got %b want %b", outs, O_BRANCH);
    end
    tick();
    idle_inputs();
  endtask

  // Three wait cycles with a taken branch held in EX; the branch flushes only on release.
  task automatic test_mem_wait();
    mem_req = 1'b1; ready = 1'b0; branch = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (outs !== O_FREEZE) begin
        bad++; $display("FAIL mem_wait_freeze[%0d]: got %b want %b", i, outs, O_FREEZE);
      end
      tick();
    end
    ready = 1'b1;
    #1;
    total++;
    if (outs !== O_BRANCH) begin
      bad++; $display("FAIL release_branch_flush: got %b want %b", outs, O_BRANCH);
    end
    tick();
    idle_inputs();
    #1;
    total++;
    if (outs !== O_NORMAL) begin
      bad++; $display("FAIL after_release_idle: got %b want %b", outs, O_NORMAL);
    end
  endtask

  // Runs right after test_mem_wait: a stale wait counter would raise the error too early.
  task automatic test_timeout_err();
    mem_req = 1'b1; ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (outs !== O_FREEZE) begin
        bad++; $display("FAIL timeout_freeze[%0d]: got %b want %b", i, outs, O_FREEZE);
      end
      tick();
    end
    total++;
    if (outs !== O_ERR) begin
      bad++; $display("FAIL enter_err: got %b want %b", outs, O_ERR);
    end
    idle_inputs();
    tick();
    tick();
    total++;
    if (outs !== O_ERR) begin
      bad++; $display("FAIL err_sticky: got %b want %b", outs, O_ERR);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (outs !== O_RESET) begin
      bad++; $display("FAIL async_reset_err: got %b want %b", outs, O_RESET);
    end
    rst = 1'b0;
    #1;
    total++;
    if (outs !== O_NORMAL) begin
      bad++; $display("FAIL err_cleared_by_reset: got %b want %b", outs, O_NORMAL);
    end
    tick();
  endtask

  // Reset mid-WAIT must drop the freeze immediately and leave a fresh IDLE.
  task automatic test_reset_mid_wait();
    mem_req = 1'b1; ready = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (outs !== O_RESET) begin
      bad++; $display("FAIL async_reset_wait: got %b want %b", outs, O_RESET);
    end
    idle_inputs();
    rst = 1'b0;
    #1;
    total++;
    if (outs !== O_NORMAL) begin
      bad++; $display("FAIL wait_cleared_by_reset: got %b want %b", outs, O_NORMAL);
    end
    tick();
  endtask

  task automatic test_stall_cnt();
    logic [31:0] exp_cnt;
`ifdef STALL_CNT_EN
    exp_cnt = 32'd4;
`else
    exp_cnt = 32'd0;
`endif
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    mem_req = 1'b1; ready = 1'b0;
    tick();
    tick();
    tick();
    ready = 1'b1;
    tick();
    idle_inputs();
    mem_read = 1'b1; rd = 5'd5; rs2 = 5'd5;
    tick();
    idle_inputs();
    tick();
    total++;
    if (stall_cnt !== exp_cnt) begin
      bad++; $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, exp_cnt);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_rd_zero();
    test_branch_priority();
    test_mem_wait();
    test_timeout_err();
    test_reset_mid_wait();
    test_stall_cnt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 15, maximum consecutive data-memory wait cycles before error (range 1..15).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 IDEXMemRead_in  input  1  instruction in EX is a load.
REQ-005 IDEXRd_in  input  5  destination register of instruction in EX.
REQ-006 IFIDRs1_in, IFIDRs2_in  input  5 each  source registers of instruction in ID.
REQ-007 BranchTaken_in  input  1  branch/jump in EX resolved taken.
REQ-008 MEMReq_in  input  1  instruction in MEM accesses data memory.
REQ-009 DmemReady_in  input  1  data memory completes the access this cycle.
REQ-010 PCWrite_out, IFIDWrite_out, IDEXWrite_out, EXMEMWrite_out  output  1 each  stage-register load enables.
REQ-011 IFIDFlush_out, IDEXFlush_out  output  1 each  zero control fields of that stage register at the next edge.
REQ-012 MEMWBBubble_out  output  1  load a bubble (MemtoReg=0, RegWrite=0) into MEM/WB at the next edge.
REQ-013 MemErr_out  output  1  sticky memory-timeout error.
REQ-014 StallCnt_out  output  32  stall-cycle count (see Configuration).

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and ERR; all outputs except counters are combinational from state and inputs.
REQ-016 Freeze SHALL be (IDLE and MEMReq_in and !DmemReady_in) or (WAIT and !DmemReady_in) or ERR.
REQ-017 During freeze: all four Write outputs = 0, both flushes = 0, MEMWBBubble_out = 1.
REQ-018 IDLE -> WAIT when MEMReq_in and !DmemReady_in; the wait counter loads 1.
REQ-019 In WAIT with DmemReady_in = 1: -> IDLE, counter cleared, no freeze that cycle.
REQ-020 In WAIT with !DmemReady_in: counter increments; when counter = TIMEOUT -> ERR on the next edge.
REQ-021 ERR SHALL be absorbing until rst; MemErr_out = 1 in ERR only.
REQ-022 Branch flush (no freeze, BranchTaken_in = 1): IFIDFlush_out = 1, IDEXFlush_out = 1, all Write outputs = 1.
REQ-023 Load-use (no freeze, no branch): IDEXMemRead_in and IDEXRd_in != 0 and IDEXRd_in equals IFIDRs1_in or IFIDRs2_in -> PCWrite_out = 0, IFIDWrite_out = 0, IDEXFlush_out = 1; other Writes = 1.
REQ-024 Priority SHALL be freeze > branch flush > load-use stall; a branch seen during freeze is held in EX and flushes in the cycle freeze releases.
REQ-025 Rd = x0 SHALL never cause a load-use stall.
REQ-026 Default (none of the above): all Writes = 1, flushes = 0, bubble = 0.

Reset
REQ-027 While rst = 1: state IDLE, wait counter 0, MemErr_out 0, StallCnt_out 0, all Write outputs 0, flushes 0, MEMWBBubble_out 0.
REQ-028 Reset asserted mid-WAIT or in ERR SHALL return to IDLE immediately, without waiting for a clock edge.
REQ-029 First edge after rst deasserts SHALL follow normal Function rules.

Configuration
REQ-030 Macro STALL_CNT_EN defined: StallCnt_out increments each cycle in which PCWrite_out = 0 and rst = 0, saturating at 32'hFFFFFFFF.
REQ-031 Macro STALL_CNT_EN undefined: StallCnt_out SHALL be constant 0 and no counter flops are implemented.

Verification
REQ-032 IDEXMemRead=1, IDEXRd=5, IFIDRs2=5, one cycle -> PCWrite=0, IFIDWrite=0, IDEXFlush=1 for exactly that cycle.
REQ-033 Same as REQ-032 with IDEXRd=0 -> no stall; all Writes=1.
REQ-034 MEMReq=1, DmemReady low 3 cycles then high -> freeze + bubble 3 cycles, IDLE on 4th, counter 0.
REQ-035 TIMEOUT=4, MEMReq=1, DmemReady held low -> ERR after 4 WAIT cycles, MemErr=1 sticky; async rst mid-cycle -> MemErr=0 immediately.
REQ-036 BranchTaken=1 together with load-use hazard -> both flushes=1, PCWrite=1; BranchTaken during freeze -> flush only on release cycle.
REQ-037 STALL_CNT_EN defined, 3-cycle mem wait plus 1 load-use -> StallCnt_out = 4; undefined -> 0.
